instr_fetch_sequencer: RTL and testbench
========================================

# instr_fetch_sequencer

Fetch and step-timing stage upstream of the control unit. Requests 16-bit instruction words from instruction memory over a req/ack handshake and latches each into the instruction register `iin`. Drives the 2-bit step counter `Contador` through steps 0–3 for every fetched instruction. The control unit decodes `iin` and issues datapath enables on each `Contador` change.

## Interface
- `ADDR_W`, default 8: instruction address width; the PC wraps modulo 2^ADDR_W.
- `START_ADDR`, default 0: PC value after reset.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `Resetn`  in  1  reset. Asynchronous and active-high: `Resetn`=1 resets the block immediately.
- `run`  in  1  execution enable; sampled only at instruction boundaries.
- `mem_req`  out  1  fetch request to instruction memory.
- `mem_addr`  out  ADDR_W  fetch address; equals the PC.
- `mem_ack`  in  1  memory has data; one-cycle pulse.
- `mem_rdata`  in  16  instruction word; valid in the cycle `mem_ack`=1.
- `iin`  out  16  instruction register, fed to the control unit.
- `Contador`  out  2  execution step, fed to the control unit.
- `busy`  out  1  high in FETCH and EXEC.
- `halted`  out  1  high in HALT.

## Operation
- States:
  - IDLE: no fetch in progress.
  - FETCH: request outstanding.
  - EXEC: instruction executing.
  - HALT: stopped until reset.
- Reset values:
  - State is IDLE.
  - PC = START_ADDR.
  - `iin`=16'h0000, `Contador`=2'b11, `mem_req`=0, `busy`=0, `halted`=0.
- IDLE: if `run`=1, go to FETCH next cycle; otherwise stay in IDLE.
- FETCH:
  - `mem_req`=1, `mem_addr`=PC, both held stable until ack.
  - On a rising edge with `mem_ack`=1: `iin`<=`mem_rdata`, PC<=PC+1 (wraps), `Contador`<=0, state<=EXEC.
- EXEC:
  - `Contador` increments by 1 each cycle: 0→1→2→3.
  - On the edge where `Contador`=3: go to FETCH if `run`=1, else IDLE. `Contador` stays at 3.
- `Contador` is held at 3 in IDLE, FETCH and HALT. The 3→0 transition therefore marks a newly latched `iin`.
- `iin` changes only on an accepted ack. It is stable for all of steps 0–3.
- `mem_ack` is ignored when `mem_req`=0, i.e. in IDLE, EXEC and HALT; no state changes.
- Deasserting `run` mid-instruction does not abort it. The current instruction finishes all four steps, then the block enters IDLE.
- Reset asserted mid-fetch or mid-exec:
  - All outputs take their reset values immediately (asynchronously).
  - `mem_req` drops.
  - A pending ack is discarded.
  - After reset is released, fetching restarts at START_ADDR.

## Timing
- Zero-wait memory: `mem_ack` may be high in the first FETCH cycle.
  - Instruction cost is 1 fetch cycle + 4 step cycles = 5 cycles.
  - With N wait states the cost is 5+N cycles.
- From reset release with `run`=1:
  - Cycle 1: IDLE.
  - Cycle 2: first `mem_req`=1.
- Latency from `iin` update to `Contador`=0: 0 cycles; both update on the same edge.

## Configuration
- Macro: `FETCH_HALT_OPCODE_EN`.
- Defined:
  - An accepted word with `mem_rdata[15:13]`=3'b011 is latched into `iin`, and PC increments.
  - The block then enters HALT instead of EXEC. `Contador` stays 3, `halted`=1, `busy`=0.
  - Only reset leaves HALT.
- Undefined:
  - Opcode 3'b011 runs steps 0–3 like any other instruction.
  - HALT is unreachable and `halted` is tied to 0.

## Test plan
- Reset: `Resetn`=1 for 2 cycles mid-run → `Contador`=3, `iin`=0, `mem_addr`=START_ADDR, `mem_req`=0, `busy`=0, all asserted asynchronously.
- Zero-wait stream: `run`=1, memory acks immediately with 16'h0480 @0 and 16'h2500 @1 → `iin`=16'h0480 with `Contador` 0,1,2,3; then `mem_addr`=1 and `iin`=16'h2500 exactly 5 cycles later.
- Wait states and stray ack:
  - Ack delayed 3 cycles → `mem_req`=1 and `mem_addr` constant for 4 cycles, `Contador` held at 3.
  - An ack pulse injected during EXEC → no change to `iin`, PC or step.
- Run drop: deassert `run` at `Contador`=1 → steps 2 and 3 still occur, then IDLE with `mem_req`=0; reassert `run` → fetch resumes at the next PC.
- Halt (macro defined): 16'h6000 @2 → `iin`=16'h6000, `mem_addr`=3, `halted`=1, `Contador` stays 3, no further `mem_req`. Macro undefined → steps 0–3 run and fetch continues at address 3.
- Wrap and reset mid-exec:
  - ADDR_W=4, START_ADDR=14 → fetch addresses 14, 15, 0.
  - Reset at `Contador`=2 → immediate reset values; restart at address 14.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch and four-step timing sequencer that feeds iin and Contador to the control unit.
// Define FETCH_HALT_OPCODE_EN to make opcode 3'b011 stop the sequencer in HALT until reset.
module instr_fetch_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clock,
    input  logic              Resetn,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       iin,
    output logic [1:0]        Contador,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC    = ADDR_W'(START_ADDR);
    localparam logic [2:0]        HALT_OPCODE = 3'b011;
    localparam logic [1:0]        LAST_STEP   = 2'd3;

`ifdef FETCH_HALT_OPCODE_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              is_halt;

    assign is_halt  = HALT_EN && (mem_rdata[15:13] == HALT_OPCODE);
    assign mem_addr = pc;

`ifdef FETCH_HALT_OPCODE_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge Resetn) begin
        if (Resetn) begin
            state    <= IDLE;
            pc       <= START_PC;
            iin      <= 16'h0000;
            Contador <= LAST_STEP;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    // Request and address stay put until the memory acknowledges.
                    if (mem_ack) begin
                        iin     <= mem_rdata;
                        pc      <= pc + ADDR_W'(1);
                        mem_req <= 1'b0;
                        if (is_halt) begin
                            state <= HALT;
                            busy  <= 1'b0;
                        end else begin
                            state    <= EXEC;
                            Contador <= 2'd0;
                        end
                    end
                end
                EXEC: begin
                    // run is only looked at on the last step, so an instruction is never cut short.
                    if (Contador == LAST_STEP) begin
                        state   <= run ? FETCH : IDLE;
                        mem_req <= run;
                        busy    <= run;
                    end else begin
                        Contador <= Contador + 2'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed scoreboard bench for instr_fetch_sequencer: default instance plus an ADDR_W=4, START_ADDR=14 instance.
// Honours FETCH_HALT_OPCODE_EN the same way the design does.
module tb_instr_fetch_sequencer;

    logic        clock = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        run = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'hdead;
    logic        sel = 1'b0;

    logic        a_req, a_busy, a_halted;
    logic [7:0]  a_addr;
    logic [15:0] a_iin;
    logic [1:0]  a_cnt;
    logic        b_req, b_busy, b_halted;
    logic [3:0]  b_addr;
    logic [15:0] b_iin;
    logic [1:0]  b_cnt;

    logic        o_req, o_busy, o_halted;
    logic [7:0]  o_addr;
    logic [15:0] o_iin;
    logic [1:0]  o_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_iin = 16'h0000;

    instr_fetch_sequencer dut_a (
        .clock(clock), .Resetn(rst_a), .run(run),
        .mem_req(a_req), .mem_addr(a_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .iin(a_iin), .Contador(a_cnt), .busy(a_busy), .halted(a_halted)
    );

    instr_fetch_sequencer #(.ADDR_W(4), .START_ADDR(14)) dut_b (
        .clock(clock), .Resetn(rst_b), .run(run),
        .mem_req(b_req), .mem_addr(b_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .iin(b_iin), .Contador(b_cnt), .busy(b_busy), .halted(b_halted)
    );

    // The instance not under test is held in reset; sel picks which one the tasks observe.
    assign o_req    = sel ? b_req : a_req;
    assign o_busy   = sel ? b_busy : a_busy;
    assign o_halted = sel ? b_halted : a_halted;
    assign o_addr   = sel ? {4'h0, b_addr} : a_addr;
    assign o_iin    = sel ? b_iin : a_iin;
    assign o_cnt    = sel ? b_cnt : a_cnt;

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic [7:0] start);
        check({tag, "_cnt"}, 32'(o_cnt), 32'd3);
        check({tag, "_iin"}, 32'(o_iin), 32'h0);
        check({tag, "_addr"}, 32'(o_addr), 32'(start));
        check({tag, "_req"}, 32'(o_req), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_halted"}, 32'(o_halted), 32'd0);
    endtask

    task automatic check_idle(input string tag, input logic [7:0] addr);
        check({tag, "_req"}, 32'(o_req), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_cnt"}, 32'(o_cnt), 32'd3);
        check({tag, "_addr"}, 32'(o_addr), 32'(addr));
        check({tag, "_iin"}, 32'(o_iin), 32'(last_iin));
    endtask

    // Entered at the sample point of the first FETCH cycle; leaves at the sample point after the ack edge.
    task automatic fetch(input logic [7:0] addr, input logic [7:0] next, input logic [15:0] data,
                         input int waits, input bit halt);
        logic [15:0] exp_iin;
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req", 32'(o_req), 32'd1);
            check("fetch_addr", 32'(o_addr), 32'(addr));
            check("fetch_step", 32'(o_cnt), 32'd3);
            check("fetch_iin_hold", 32'(o_iin), 32'(last_iin));
            if (i < waits) tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        exp_q.push_back(data);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'hdead;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            exp_iin = 16'hxxxx;
        end else begin
            exp_iin = exp_q.pop_front();
        end
        check("latch_iin", 32'(o_iin), 32'(exp_iin));
        check("latch_addr", 32'(o_addr), 32'(next));
        check("latch_req", 32'(o_req), 32'd0);
        check("latch_step", 32'(o_cnt), halt ? 32'd3 : 32'd0);
        check("latch_busy", 32'(o_busy), halt ? 32'd0 : 32'd1);
        check("latch_halted", 32'(o_halted), halt ? 32'd1 : 32'd0);
        last_iin = exp_iin;
    endtask

    // Walks steps 1..3; stray injects an ack during step 'stray', drop clears run at step 'drop'.
    task automatic exec_steps(input logic [7:0] addr, input int stray, input int drop);
        for (int k = 1; k <= 3; k++) begin
            if (k - 1 == stray) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hffff;
            end
            if (k - 1 == drop) run = 1'b0;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'hdead;
            check("exec_step", 32'(o_cnt), 32'(k));
            check("exec_iin", 32'(o_iin), 32'(last_iin));
            check("exec_addr", 32'(o_addr), 32'(addr));
            check("exec_req", 32'(o_req), 32'd0);
        end
    endtask

    initial begin
        // Reset state of the default instance.
        tick();
        tick();
        check_reset("reset_a", 8'd0);

        // Release with run high: one IDLE cycle, then the request.
        rst_a = 1'b0;
        run   = 1'b1;
        check("idle_req", 32'(o_req), 32'd0);
        tick();

        // Zero-wait stream: the second word lands exactly five cycles after the first.
        fetch(8'd0, 8'd1, 16'h0480, 0, 1'b0);
        exec_steps(8'd1, -1, -1);
        tick();
        fetch(8'd1, 8'd2, 16'h2500, 0, 1'b0);

        // Stray ack in EXEC and run dropped at step 1.
        exec_steps(8'd2, 0, 1);
        tick();
        check_idle("rundrop_idle", 8'd2);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_idle("idle_stray_ack", 8'd2);
        run = 1'b1;
        tick();

        // Three wait states before the ack.
`ifdef FETCH_HALT_OPCODE_EN
        fetch(8'd2, 8'd3, 16'h6000, 3, 1'b1);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_ack = 1'b0;
            check("halt_req", 32'(o_req), 32'd0);
            check("halt_halted", 32'(o_halted), 32'd1);
            check("halt_step", 32'(o_cnt), 32'd3);
            check("halt_addr", 32'(o_addr), 32'd3);
            check("halt_iin", 32'(o_iin), 32'h6000);
        end
`else
        fetch(8'd2, 8'd3, 16'h6000, 3, 1'b0);
        exec_steps(8'd3, -1, -1);
        tick();
        fetch(8'd3, 8'd4, 16'h1234, 0, 1'b0);
        tick();
        tick();
        check("pre_reset_step", 32'(o_cnt), 32'd2);
`endif

        // Asynchronous reset between clock edges, held for two cycles.
        #2;
        rst_a = 1'b1;
        #1;
        check_reset("async_reset_a", 8'd0);
        tick();
        tick();
        check_reset("held_reset_a", 8'd0);
        last_iin = 16'h0000;
        rst_a = 1'b0;
        tick();
        fetch(8'd0, 8'd1, 16'h0abc, 0, 1'b0);

        // Second instance: narrow PC wraps 14, 15, 0.
        rst_a = 1'b1;
        run   = 1'b0;
        sel   = 1'b1;
        last_iin = 16'h0000;
        tick();
        check_reset("reset_b", 8'd14);
        rst_b = 1'b0;
        run   = 1'b1;
        tick();
        fetch(8'd14, 8'd15, 16'ha001, 0, 1'b0);
        exec_steps(8'd15, -1, -1);
        tick();
        fetch(8'd15, 8'd0, 16'ha002, 0, 1'b0);
        exec_steps(8'd0, -1, -1);
        tick();
        fetch(8'd0, 8'd1, 16'ha003, 0, 1'b0);
        tick();
        tick();
        check("b_pre_reset_step", 32'(o_cnt), 32'd2);
        #2;
        rst_b = 1'b1;
        #1;
        check_reset("async_reset_b", 8'd14);
        tick();
        tick();
        last_iin = 16'h0000;
        rst_b = 1'b0;
        tick();
        fetch(8'd14, 8'd15, 16'ha004, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
